// File: rtl/oclib_csr_tree_router_if.sv
// CSR tree router bus: upstream request/response plus the fanned-out downstream ports.
// The router connects through the slave modport; its environment uses the master modport.
interface oclib_csr_tree_router_if #(
  parameter int Outputs      = 8,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int BlockIdBits  = 16
);
  // Upstream side
  logic                         inRead;
  logic                         inWrite;
  logic [BlockIdBits-1:0]       inToBlock;
  logic [AddressWidth-1:0]      inAddress;
  logic [DataWidth-1:0]         inWdata;
  logic                         inReady;
  logic                         inError;
  logic [DataWidth-1:0]         inRdata;
  // Downstream side
  logic [Outputs-1:0]           outRead;
  logic [Outputs-1:0]           outWrite;
  logic [AddressWidth-1:0]      outAddress;
  logic [DataWidth-1:0]         outWdata;
  logic [Outputs-1:0]           outReady;
  logic [Outputs-1:0]           outError;
  logic [Outputs*DataWidth-1:0] outRdata;

  modport slave (
    input  inRead, inWrite, inToBlock, inAddress, inWdata, outReady, outError, outRdata,
    output inReady, inError, inRdata, outRead, outWrite, outAddress, outWdata
  );

  modport master (
    output inRead, inWrite, inToBlock, inAddress, inWdata, outReady, outError, outRdata,
    input  inReady, inError, inRdata, outRead, outWrite, outAddress, outWdata
  );
endinterface

// File: rtl/oclib_csr_tree_router.sv
// CSR tree router: forwards one upstream CSR request to the downstream port selected by
// key/mask decode of the block ID (lowest index wins), and always answers upstream --
// unmatched IDs and silent targets come back as errors instead of hanging the tree.
module oclib_csr_tree_router #(
  parameter int Outputs      = 8,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int BlockIdBits  = 16,
  // All-ones key additionally means "match toblock == port index".
  parameter logic [Outputs-1:0][BlockIdBits-1:0] OutputBlockIdKey  = '1,
  parameter logic [Outputs-1:0][BlockIdBits-1:0] OutputBlockIdMask = '0,
  parameter int TimeoutCycles     = 1024,
  parameter bit DecodeErrorEnable = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  oclib_csr_tree_router_if.slave bus,
  output logic                  timeoutEvent,
  output logic [7:0]            timeoutCount
);
  localparam int SelBits = (Outputs > 1) ? $clog2(Outputs) : 1;

  typedef enum logic [2:0] {Idle, Decode, Access, Respond, Wait} state_t;

  state_t                  state_r, stateNext_s;
  logic [AddressWidth-1:0] address_r;
  logic [DataWidth-1:0]    wdata_r;
  logic [BlockIdBits-1:0]  toBlock_r;
  logic                    isWrite_r;
  logic [SelBits-1:0]      sel_r;
  logic [31:0]             accessCount_r;
  logic                    respError_r;
  logic [DataWidth-1:0]    respRdata_r;
  logic [Outputs-1:0]      outRead_r, outWrite_r;
  logic                    inReady_r, inError_r;
  logic [DataWidth-1:0]    inRdata_r;
  logic                    timeoutEvent_r;
  logic [7:0]              timeoutCount_r;

  logic [Outputs-1:0]      matchVec_s;
  logic                    decodeHit_s;
  logic                    decodeFail_s;
  logic [SelBits-1:0]      decodeSel_s;
  logic [Outputs-1:0]      selOneHot_s;
  logic                    request_s;
  logic                    readyHit_s;
  logic                    timeoutHit_s;

  // Lowest set index of a match vector; zero when nothing matches (the fallback port).
  function automatic logic [SelBits-1:0] lowestIndex(input logic [Outputs-1:0] vec);
    logic [SelBits-1:0] idx;
    idx = '0;
    for (int i = Outputs - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = SelBits'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  for (genvar i = 0; i < Outputs; i++) begin : gMatch
    assign matchVec_s[i] =
      ((toBlock_r & ~OutputBlockIdMask[i]) == (OutputBlockIdKey[i] & ~OutputBlockIdMask[i])) ||
      ((OutputBlockIdKey[i] == {BlockIdBits{1'b1}}) && (toBlock_r == BlockIdBits'(i)));
  end

  assign decodeHit_s  = |matchVec_s;
  assign decodeFail_s = !decodeHit_s && DecodeErrorEnable;
  assign decodeSel_s  = lowestIndex(matchVec_s);
  assign selOneHot_s  = Outputs'(1'b1) << decodeSel_s;
  assign request_s    = bus.inRead || bus.inWrite;
  // Only the selected port's feedback is looked at.
  assign readyHit_s   = bus.outReady[sel_r];
  // Ready in the expiry cycle beats the timeout.
  assign timeoutHit_s = (TimeoutCycles != 0) && !readyHit_s &&
                        ((accessCount_r + 32'd1) == 32'(TimeoutCycles));

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= Idle;
    else       state_r <= stateNext_s;
  end

  // FSM next-state decode.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      Idle: begin
        if (request_s) stateNext_s = Decode;
        else           stateNext_s = Idle;
      end
      Decode: begin
        if (decodeFail_s) stateNext_s = Respond;
        else              stateNext_s = Access;
      end
      Access: begin
        if (readyHit_s || timeoutHit_s) stateNext_s = Respond;
        else                            stateNext_s = Access;
      end
      Respond: stateNext_s = Wait;
      Wait: begin
        if (!request_s) stateNext_s = Idle;
        else            stateNext_s = Wait;
      end
      default: stateNext_s = Idle;
    endcase
  end

  // Request capture, downstream strobes, response latching and timeout bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      address_r      <= '0;
      wdata_r        <= '0;
      toBlock_r      <= '0;
      isWrite_r      <= 1'b0;
      sel_r          <= '0;
      accessCount_r  <= 32'd0;
      respError_r    <= 1'b0;
      respRdata_r    <= '0;
      outRead_r      <= '0;
      outWrite_r     <= '0;
      inReady_r      <= 1'b0;
      inError_r      <= 1'b0;
      inRdata_r      <= '0;
      timeoutEvent_r <= 1'b0;
      timeoutCount_r <= 8'd0;
    end else begin
      inReady_r      <= 1'b0;
      inError_r      <= 1'b0;
      inRdata_r      <= '0;
      timeoutEvent_r <= 1'b0;
      case (state_r)
        Idle: begin
          if (request_s) begin
            address_r <= bus.inAddress;
            wdata_r   <= bus.inWdata;
            toBlock_r <= bus.inToBlock;
            isWrite_r <= bus.inWrite;   // write wins when both are raised
          end
        end
        Decode: begin
          accessCount_r <= 32'd0;
          sel_r         <= decodeSel_s;
          if (decodeFail_s) begin
            respError_r <= 1'b1;
            respRdata_r <= '0;
          end else begin
            outRead_r  <= isWrite_r ? '0 : selOneHot_s;
            outWrite_r <= isWrite_r ? selOneHot_s : '0;
          end
        end
        Access: begin
          if (readyHit_s) begin
            outRead_r   <= '0;
            outWrite_r  <= '0;
            respError_r <= bus.outError[sel_r];
            respRdata_r <= isWrite_r ? '0 : bus.outRdata[sel_r*DataWidth +: DataWidth];
          end else if (timeoutHit_s) begin
            outRead_r      <= '0;
            outWrite_r     <= '0;
            respError_r    <= 1'b1;
            respRdata_r    <= '0;
            timeoutEvent_r <= 1'b1;
            if (timeoutCount_r != 8'hFF) timeoutCount_r <= timeoutCount_r + 8'd1;
            else                         timeoutCount_r <= timeoutCount_r;
          end else begin
            accessCount_r <= accessCount_r + 32'd1;
          end
        end
        Respond: begin
          inReady_r <= 1'b1;
          inError_r <= respError_r;
          inRdata_r <= respRdata_r;
        end
        default: begin
          inReady_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inReady    = inReady_r;
  assign bus.inError    = inError_r;
  assign bus.inRdata    = inRdata_r;
  assign bus.outRead    = outRead_r;
  assign bus.outWrite   = outWrite_r;
  assign bus.outAddress = address_r;
  assign bus.outWdata   = wdata_r;
  assign timeoutEvent   = timeoutEvent_r;
  assign timeoutCount   = timeoutCount_r;
endmodule
